spio_hss_multiplexer_pkt_store_gbn: RTL

Parametrised go-back-N retransmission store for the spiNNlink frame assembler. It holds packets from the local packet interface until the remote end acknowledges them. It issues packets to frame issue tagged with their own sequence numbers. It rewinds and resends on a nak or on an acknowledge timeout, and gates issue on remote channel flow control when enabled.

---
 rtl/spio_hss_multiplexer_pkt_store_gbn.sv | 104 ++++++++++
 1 files changed

// File: rtl/spio_hss_multiplexer_pkt_store_gbn.sv
// Go-back-N retransmission store: holds packets until acked, issues them
// tagged with sequence numbers, rewinds on nak or ack timeout.
module spio_hss_multiplexer_pkt_store_gbn #(
    parameter int PKT_BITS  = 72,
    parameter int ADDR_BITS = 3,
    parameter int SEQ_BITS  = 6,
    parameter int TIMEOUT   = 1024,
    parameter int CFC_EN    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PKT_BITS-1:0]  pkt_data,
    input  logic                 pkt_vld,
    output logic                 pkt_rdy,
    output logic [PKT_BITS-1:0]  bpkt_data,
    output logic [SEQ_BITS-1:0]  bpkt_seq,
    output logic                 bpkt_vld,
    input  logic                 bpkt_rdy,
    input  logic                 cfc_rem,
    input  logic                 vld_ack,
    input  logic                 vld_nak,
    input  logic [SEQ_BITS-1:0]  ack_seq,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_BITS:0]   occupancy,
    output logic                 rsnd_tmo,
    output logic                 bad_ack
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int OW    = ADDR_BITS + 1;
    localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [PKT_BITS-1:0] r_mem [DEPTH];
    logic [SEQ_BITS-1:0] r_sa, r_sr, r_sw;
    logic [SEQ_BITS-1:0] w_sa_n, w_sr_n, w_win, w_off;
    logic [TW-1:0]       r_tmr, w_tmr_n;
    logic                r_tmo, r_bad;
    logic                w_wr, w_xfer, w_any, w_vok, w_tmo;
    logic [OW-1:0]       w_occ;

    assign w_occ     = OW'(r_sw - r_sa);
    assign occupancy = w_occ;
    assign full      = (w_occ == OW'(DEPTH));
    assign empty     = (w_occ == '0);
    assign pkt_rdy   = !full;
    assign w_wr      = pkt_vld && pkt_rdy;

    assign bpkt_vld  = (r_sr != r_sw) && (cfc_rem || (CFC_EN == 0));
    assign bpkt_seq  = r_sr;
    assign bpkt_data = r_mem[r_sr[ADDR_BITS-1:0]];
    assign rsnd_tmo  = r_tmo;
    assign bad_ack   = r_bad;

    always_comb begin
        w_win  = r_sr - r_sa;
        w_off  = ack_seq - r_sa;
        w_any  = vld_ack || vld_nak;
        w_vok  = w_any && (w_off < w_win);
        w_xfer = bpkt_vld && bpkt_rdy;
        // a valid ack/nak in the expiry cycle wins over the timeout rewind
        w_tmo  = (TIMEOUT != 0) && (r_tmr == TLIM) && !w_vok && (w_win != '0);

        w_sa_n = r_sa;
        if (w_vok)
            w_sa_n = vld_nak ? ack_seq : ack_seq + SEQ_BITS'(1);

        w_sr_n = r_sr;
        if (w_vok && vld_nak)
            w_sr_n = ack_seq;
        else if (w_tmo)
            w_sr_n = r_sa;
        else if (w_xfer)
            w_sr_n = r_sr + SEQ_BITS'(1);

        w_tmr_n = r_tmr + TW'(1);
        if (w_tmo || (w_sa_n != r_sa) || (w_win == '0))
            w_tmr_n = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa  <= '0;
            r_sr  <= '0;
            r_sw  <= '0;
            r_tmr <= '0;
            r_tmo <= 1'b0;
            r_bad <= 1'b0;
        end else begin
            r_sa  <= w_sa_n;
            r_sr  <= w_sr_n;
            r_sw  <= w_wr ? r_sw + SEQ_BITS'(1) : r_sw;
            r_tmr <= w_tmr_n;
            r_tmo <= w_tmo;
            r_bad <= w_any && !w_vok;
        end
    end

    // storage is not reset; reads while empty are don't-care
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_sw[ADDR_BITS-1:0]] <= pkt_data;
    end
endmodule
